// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-requester arbiter and sequencer for the shared iterative divider
module div_arbiter #(
  parameter bit FAIR      = 1'b1,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [1:0]  req_i,
  input  logic [1:0]  signed_i,
  input  logic [31:0] op1_0_i,
  input  logic [31:0] op2_0_i,
  input  logic [31:0] op1_1_i,
  input  logic [31:0] op2_1_i,
  input  logic [1:0]  annul_i,
  output logic [1:0]  grant_o,
  output logic [1:0]  done_o,
  output logic [63:0] result_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  localparam int CW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_owner_q;
  logic [CW-1:0] drain_cnt_q;
  logic [1:0]    elig_d;
  logic          owner_d;

  // An annulled requester is never eligible, even if it still shows req.
  always_comb begin
    elig_d  = req_i & ~annul_i;
    owner_d = 1'b0;
    if (elig_d == 2'b10) begin
      owner_d = 1'b1;
    end else if (elig_d == 2'b11 && FAIR) begin
      owner_d = ~last_owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      drain_cnt_q  <= '0;
      grant_o      <= '0;
      done_o       <= '0;
      result_o     <= '0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
    end else begin
      done_o      <= '0;
      div_annul_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|elig_d) begin
            owner_q      <= owner_d;
            last_owner_q <= owner_d;
            grant_o      <= owner_d ? 2'b10 : 2'b01;
            div_start_o  <= 1'b1;
            div_signed_o <= signed_i[owner_d];
            div_op1_o    <= owner_d ? op1_1_i : op1_0_i;
            div_op2_o    <= owner_d ? op2_1_i : op2_0_i;
            state_q      <= RUN;
          end
        end
        RUN: begin
          // Abort beats a coincident ready: the flushed client must not see done.
          if (annul_i[owner_q]) begin
            div_annul_o <= 1'b1;
            div_start_o <= 1'b0;
            grant_o     <= '0;
            drain_cnt_q <= '0;
            state_q     <= DRAIN;
          end else if (div_ready_i) begin
            result_o    <= div_result_i;
            done_o      <= owner_q ? 2'b10 : 2'b01;
            div_start_o <= 1'b0;
            grant_o     <= '0;
            drain_cnt_q <= '0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == CW'(DRAIN_CYC - 1)) begin
            state_q <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter with a behavioural divider
module tb_div_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, sgn, annul;
  logic [31:0] a0, b0, a1, b1;
  logic        auto_en, ready_ovr;

  logic [1:0]  f_grant, f_done, x_grant, x_done;
  logic [63:0] f_result, x_result, f_div_result, x_div_result;
  logic        f_start, f_annul, f_signed, f_ready;
  logic        x_start, x_annul, x_signed, x_ready;
  logic [31:0] f_op1, f_op2, x_op1, x_op2;
  logic [5:0]  f_cnt, x_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int m_last   = 1;
  bit mon_en   = 0;
  bit x_prev   = 0;
  int x_bad    = 0;
  int x_gcnt   = 0;

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int rr_pick(input logic [1:0] elig, input int last);
    if (elig == 2'b01) return 0;
    if (elig == 2'b10) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  div_arbiter #(.FAIR(1'b1), .DRAIN_CYC(2)) u_fair (
    .clk(clk), .Rst_n(rst_n), .req_i(req), .signed_i(sgn),
    .op1_0_i(a0), .op2_0_i(b0), .op1_1_i(a1), .op2_1_i(b1), .annul_i(annul),
    .grant_o(f_grant), .done_o(f_done), .result_o(f_result),
    .div_start_o(f_start), .div_annul_o(f_annul), .div_signed_o(f_signed),
    .div_op1_o(f_op1), .div_op2_o(f_op2),
    .div_result_i(f_div_result), .div_ready_i(f_ready)
  );

  div_arbiter #(.FAIR(1'b0), .DRAIN_CYC(2)) u_fix (
    .clk(clk), .Rst_n(rst_n), .req_i(req), .signed_i(sgn),
    .op1_0_i(a0), .op2_0_i(b0), .op1_1_i(a1), .op2_1_i(b1), .annul_i(annul),
    .grant_o(x_grant), .done_o(x_done), .result_o(x_result),
    .div_start_o(x_start), .div_annul_o(x_annul), .div_signed_o(x_signed),
    .div_op1_o(x_op1), .div_op2_o(x_op2),
    .div_result_i(x_div_result), .div_ready_i(x_ready)
  );

  // Divider: ready in the 36th start cycle, or the 3rd when the divisor is zero.
  always @(posedge clk) begin
    if (!rst_n || !f_start || f_annul) f_cnt <= '0; else f_cnt <= f_cnt + 6'd1;
    if (!rst_n || !x_start || x_annul) x_cnt <= '0; else x_cnt <= x_cnt + 6'd1;
  end
  assign f_ready = ready_ovr | (auto_en & f_start & (f_cnt == ((f_op2 == 32'd0) ? 6'd2 : 6'd35)));
  assign x_ready = ready_ovr | (auto_en & x_start & (x_cnt == ((x_op2 == 32'd0) ? 6'd2 : 6'd35)));
  assign f_div_result = ref_div(f_signed, f_op1, f_op2);
  assign x_div_result = ref_div(x_signed, x_op1, x_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (x_grant == 2'b10) x_bad++;
      if (x_grant != 2'b00 && !x_prev) x_gcnt++;
    end
    x_prev <= |x_grant;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic reset_dut;
    req = 2'b00; annul = 2'b00; ready_ovr = 1'b0; auto_en = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    m_last = 1;
  endtask

  task automatic do_single(input int who, input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit poke, input string tag);
    int n, run;
    bit stable;
    logic [1:0] oh;
    repeat (3) tick;
    oh = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    sgn[who] = sg;
    req[who] = 1'b1;
    n = 0;
    tick;
    while (f_grant == 2'b00 && n < 20) begin tick; n++; end
    check({tag, " grant"}, f_grant, oh);
    check({tag, " grant latency"}, n, 0);
    check({tag, " operands"}, {f_op1, f_op2}, {a, b});
    check({tag, " signed"}, f_signed, sg);
    run = 0; stable = 1'b1;
    while (f_done == 2'b00 && run < 60) begin
      if (!f_start || f_op1 !== a || f_op2 !== b || f_signed !== sg || f_grant !== oh) stable = 1'b0;
      if (poke) annul[1-who] = (run == 5);
      tick; run++;
    end
    annul = 2'b00;
    check({tag, " start/operands stable"}, stable, 1);
    check({tag, " done"}, f_done, oh);
    check({tag, " result"}, f_result, exp);
    if (b != 32'd0) check({tag, " latency"}, run, 36);
    else check({tag, " zero-div early"}, (run <= 5), 1);
    req[who] = 1'b0;
    tick;
    check({tag, " done one cycle"}, {f_done, f_start}, 3'b000);
    check({tag, " result held"}, f_result, exp);
  endtask

  task automatic serve_one(input int o, input bit ab, input int at, input string tag);
    int n, run;
    logic [63:0] exp;
    n = 0;
    while (f_grant == 2'b00 && n < 30) begin tick; n++; end
    check({tag, " owner"}, f_grant, (o == 1) ? 2'b10 : 2'b01);
    exp = (o == 1) ? ref_div(sgn[1], a1, b1) : ref_div(sgn[0], a0, b0);
    if (ab) begin
      repeat (at) tick;
      annul[o] = 1'b1; req[o] = 1'b0;
      tick;
      annul[o] = 1'b0;
      check({tag, " abort"}, {f_done, f_annul, f_start}, 4'b0010);
    end else begin
      run = 0;
      while (f_done == 2'b00 && run < 60) begin tick; run++; end
      check({tag, " done"}, f_done, (o == 1) ? 2'b10 : 2'b01);
      check({tag, " result"}, f_result, exp);
      req[o] = 1'b0;
      tick;
    end
  endtask

  typedef struct {
    int          who;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int n, g, acnt, dcnt, o;
    bit gap_ok;
    logic [63:0] hold;
    logic [1:0] pat;
    bit ab;

    tbl[0] = '{0, 1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    tbl[1] = '{1, 1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
    tbl[2] = '{0, 1'b0, 32'd9,          32'd3,          64'h00000000_00000003};
    tbl[3] = '{1, 1'b0, 32'd5,          32'd0,          64'h00000000_00000000};
    tbl[4] = '{1, 1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2};
    tbl[5] = '{0, 1'b0, 32'hFFFFFFFF,   32'd16,         64'h0000000F_0FFFFFFF};

    req = 2'b00; sgn = 2'b00; annul = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    auto_en = 1'b1; ready_ovr = 1'b0; rst_n = 1'b0;
    repeat (3) tick;
    check("reset ctl outputs", {f_grant, f_done, f_start, f_annul, f_signed}, 7'd0);
    check("reset operands", {f_op1, f_op2}, 64'd0);
    check("reset result", f_result, 64'd0);
    rst_n = 1'b1;

    ready_ovr = 1'b1;
    tick;
    ready_ovr = 1'b0;
    tick;
    check("ready outside RUN ignored", {f_done, f_grant, f_result[7:0]}, 12'd0);

    for (int i = 0; i < 6; i++)
      do_single(tbl[i].who, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
    do_single(0, 1'b0, 32'd77, 32'd10, 64'h00000007_00000007, 1'b1, "non-owner annul");

    // Contention from reset: fair instance alternates, fixed instance always serves requester 0.
    a0 = 32'd100; b0 = 32'd7; a1 = 32'hFFFFFFF9; b1 = 32'd2; sgn = 2'b10;
    reset_dut;
    req = 2'b11;
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0; gap_ok = 1'b1;
      while (f_grant == 2'b00 && n < 20) begin
        if (f_start) gap_ok = 1'b0;
        tick; n++;
      end
      o = rr_pick(req, m_last);
      m_last = o;
      check($sformatf("contention owner %0d", k), f_grant, (o == 1) ? 2'b10 : 2'b01);
      if (k > 0) check($sformatf("contention gap %0d", k), (n >= 3) && gap_ok, 1);
      g = 0;
      while (f_done == 2'b00 && g < 60) begin tick; g++; end
      check($sformatf("contention done %0d", k), f_done, (o == 1) ? 2'b10 : 2'b01);
      check($sformatf("contention result %0d", k), f_result,
            (o == 1) ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000002_0000000E);
    end
    mon_en = 1'b0;
    check("fixed priority never grants 1", x_bad, 0);
    check("fixed priority served 0 repeatedly", (x_gcnt >= 2), 1);

    // Abort 10 cycles into RUN.
    reset_dut;
    do_single(0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "pre-abort");
    repeat (3) tick;
    a0 = 32'd1000; b0 = 32'd3; req[0] = 1'b1;
    n = 0;
    while (f_grant == 2'b00 && n < 20) begin tick; n++; end
    check("abort grant", f_grant, 2'b01);
    repeat (10) tick;
    annul[0] = 1'b1; req[0] = 1'b0;
    tick;
    annul[0] = 1'b0;
    acnt = 0; dcnt = 0;
    for (int c = 0; c < 45; c++) begin
      if (f_annul) acnt++;
      if (f_done != 2'b00) dcnt++;
      tick;
    end
    check("abort div_annul cycles", acnt, 1);
    check("abort no done", dcnt, 0);
    check("abort result unchanged", f_result, 64'h00000002_0000000E);
    do_single(0, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "post-abort");

    // Divide by zero annulled inside its short window.
    repeat (3) tick;
    a0 = 32'd5; b0 = 32'd0; req[0] = 1'b1;
    n = 0;
    while (f_grant == 2'b00 && n < 20) begin tick; n++; end
    tick;
    annul[0] = 1'b1; req[0] = 1'b0;
    tick;
    annul[0] = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (f_done != 2'b00) dcnt++;
      tick;
    end
    check("zero-div abort no done", dcnt, 0);
    do_single(1, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "after zero-div abort");

    // Annul and ready in the same cycle.
    hold = f_result;
    repeat (3) tick;
    auto_en = 1'b0;
    a0 = 32'd50; b0 = 32'd5; req[0] = 1'b1;
    n = 0;
    while (f_grant == 2'b00 && n < 20) begin tick; n++; end
    repeat (3) tick;
    annul[0] = 1'b1; ready_ovr = 1'b1; req[0] = 1'b0;
    tick;
    annul[0] = 1'b0; ready_ovr = 1'b0;
    check("annul+ready abort wins", {f_done, f_annul}, 3'b001);
    tick;
    check("annul+ready no late done", {f_done, f_annul}, 3'b000);
    check("annul+ready result unchanged", f_result, hold);
    auto_en = 1'b1;

    // Reset in the middle of RUN.
    reset_dut;
    a1 = 32'd100; b1 = 32'd7; a0 = 32'd9; b0 = 32'd3; sgn = 2'b00;
    req = 2'b10;
    n = 0;
    while (f_grant == 2'b00 && n < 20) begin tick; n++; end
    repeat (5) tick;
    req = 2'b11;
    rst_n = 1'b0;
    tick;
    check("mid-RUN reset ctl", {f_grant, f_done, f_start, f_annul, f_signed}, 7'd0);
    check("mid-RUN reset operands", {f_op1, f_op2}, 64'd0);
    rst_n = 1'b1;
    m_last = 1;
    tick;
    check("post-reset winner", f_grant, 2'b01);
    m_last = 0;
    n = 0;
    while (f_done == 2'b00 && n < 60) begin tick; n++; end
    check("post-reset result", {f_done, f_result}, {2'b01, 64'h00000000_00000003});
    req = 2'b00;
    repeat (4) tick;

    // Randomized traffic against the arbitration/division rules.
    for (int it = 0; it < 30; it++) begin
      pat = 2'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      b1 = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if (b0 == 32'hFFFFFFFF) b0 = 32'd1;
      if (b1 == 32'hFFFFFFFF) b1 = 32'd1;
      sgn = 2'($urandom_range(0, 3));
      req = pat;
      ab = ($urandom_range(0, 3) == 0);
      for (int s = 0; s < 2; s++) begin
        if (req != 2'b00) begin
          o = rr_pick(req, m_last);
          m_last = o;
          serve_one(o, ab && (s == 0) && (((o == 1) ? b1 : b0) != 32'd0),
                    $urandom_range(1, 30), $sformatf("rand%0d.%0d", it, s));
        end
      end
      repeat (3) tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
